// File: rtl/ice40_rgb_wb_pkg.sv
// Shared constants for the iCE40 RGB LED Wishbone controller.
// Holds the register map, CTRL bit positions and the duty/prescaler widths.
package ice40_rgb_wb_pkg;

  localparam int unsigned DutyW = 8;
  localparam int unsigned PreW  = 12;

  localparam logic [4:0] AddrCtrl   = 5'h00;
  localparam logic [4:0] AddrPre    = 5'h01;
  localparam logic [4:0] AddrDuty0  = 5'h02;
  localparam logic [4:0] AddrDuty1  = 5'h03;
  localparam logic [4:0] AddrDuty2  = 5'h04;
  localparam logic [4:0] AddrStatus = 5'h05;

  localparam int unsigned CtrlEn     = 0;
  localparam int unsigned CtrlCurren = 1;
  localparam int unsigned CtrlLeden  = 2;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: software duty register, period-aligned active-duty shadow and compare.
// Ports:
//   clk_4x_s, rst : clock, synchronous active-high reset
//   we_i, wdata_i : duty register write strobe and data
//   load_i        : copy duty register into the active shadow (period wrap or PWM disabled)
//   en_i, cnt_i   : PWM enable and shared PWM counter
//   duty_o        : duty register readback
//   pwm_o         : combinational channel-on (registered by the top before the pad)
module rgb_pwm_chan
  import ice40_rgb_wb_pkg::*;
(
  input  logic             clk_4x_s,
  input  logic             rst,
  input  logic             we_i,
  input  logic [DutyW-1:0] wdata_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DutyW-1:0] cnt_i,
  output logic [DutyW-1:0] duty_o,
  output logic             pwm_o
);

  logic [DutyW-1:0] duty_q;
  logic [DutyW-1:0] active_q;

  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      duty_q   <= '0;
      active_q <= '0;
    end else begin
      if (we_i)   duty_q   <= wdata_i;
      // Shadow only follows at a period boundary so a mid-period write cannot glitch.
      if (load_i) active_q <= duty_q;
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = en_i & (cnt_i < active_q);

endmodule

// File: rtl/ice40_rgb_wb_ctrl.sv
// Wishbone-controlled three-channel RGB LED PWM driver.
// Ports:
//   clk_4x_s, rst         : clock, synchronous active-high reset
//   pad_rgb[2:0]          : LED pads, active-low in the RTL driver (bit i = channel i)
//   wb_addr, wb_wdata,
//   wb_we, wb_cyc         : Wishbone request (word address, full-word writes)
//   wb_rdata, wb_ack      : Wishbone response; two-cycle access, rdata is 0 outside ack
// Build option: define ICE40_RGB_HARD_DRV_EN to drive the pads through SB_RGBA_DRV
// (uses the current parameters); otherwise a pure RTL pad equation is used.
module ice40_rgb_wb_ctrl
  import ice40_rgb_wb_pkg::*;
#(
  parameter CURRENT_MODE = "0b1",
  parameter RGB0_CURRENT = "0b000001",
  parameter RGB1_CURRENT = "0b000001",
  parameter RGB2_CURRENT = "0b000001"
) (
  input  logic        clk_4x_s,
  input  logic        rst,
  output logic [2:0]  pad_rgb,
  input  logic [4:0]  wb_addr,
  output logic [31:0] wb_rdata,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack
);

  logic                  ack_r;
  logic [31:0]           rdata_q;
  logic [31:0]           rd_mux;
  logic [2:0]            ctrl_q;
  logic [PreW-1:0]       pre_q;
  logic [PreW-1:0]       pre_cnt_q;
  logic [DutyW-1:0]      cnt_q;
  logic [2:0][DutyW-1:0] duty;
  logic [2:0]            pwm;
  logic [2:0]            pwm_q;
  logic                  en;
  logic                  tick;
  logic                  load;
  logic                  wr;

  assign en   = ctrl_q[CtrlEn];
  assign tick = en & (pre_cnt_q == pre_q);
  // Reload the shadows as the PWM counter rolls 255 -> 0, and continuously while disabled.
  assign load = ~en | (tick & (cnt_q == {DutyW{1'b1}}));
  assign wr   = wb_cyc & wb_we & ack_r;

  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      AddrCtrl:   rd_mux = {29'd0, ctrl_q};
      AddrPre:    rd_mux = {20'd0, pre_q};
      AddrDuty0:  rd_mux = {24'd0, duty[0]};
      AddrDuty1:  rd_mux = {24'd0, duty[1]};
      AddrDuty2:  rd_mux = {24'd0, duty[2]};
      AddrStatus: rd_mux = {23'd0, tick, cnt_q};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      ack_r     <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      pwm_q     <= '0;
    end else begin
      ack_r   <= wb_cyc & ~ack_r;
      rdata_q <= (wb_cyc & ~ack_r) ? rd_mux : '0;
      if (wr && wb_addr == AddrCtrl) ctrl_q <= wb_wdata[2:0];
      if (wr && wb_addr == AddrPre)  pre_q  <= wb_wdata[PreW-1:0];
      if (!en) begin
        pre_cnt_q <= '0;
        cnt_q     <= '0;
      end else begin
        // A PRESCALE written below the current count lets the counter run on to wrap at 4095.
        pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
        if (tick) cnt_q <= cnt_q + 1'b1;
      end
      pwm_q <= pwm;
    end
  end

  assign wb_ack   = ack_r;
  assign wb_rdata = rdata_q;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    rgb_pwm_chan u_chan (
      .clk_4x_s (clk_4x_s),
      .rst      (rst),
      .we_i     (wr && (wb_addr == AddrDuty0 + 5'(i))),
      .wdata_i  (wb_wdata[DutyW-1:0]),
      .load_i   (load),
      .en_i     (en),
      .cnt_i    (cnt_q),
      .duty_o   (duty[i]),
      .pwm_o    (pwm[i])
    );
  end

`ifdef ICE40_RGB_HARD_DRV_EN
  SB_RGBA_DRV #(
    .CURRENT_MODE (CURRENT_MODE),
    .RGB0_CURRENT (RGB0_CURRENT),
    .RGB1_CURRENT (RGB1_CURRENT),
    .RGB2_CURRENT (RGB2_CURRENT)
  ) u_rgb_drv (
    .CURREN   (ctrl_q[CtrlCurren]),
    .RGBLEDEN (ctrl_q[CtrlLeden]),
    .RGB0PWM  (pwm_q[0]),
    .RGB1PWM  (pwm_q[1]),
    .RGB2PWM  (pwm_q[2]),
    .RGB0     (pad_rgb[0]),
    .RGB1     (pad_rgb[1]),
    .RGB2     (pad_rgb[2])
  );

  logic unused_bits;
  assign unused_bits = ^wb_wdata[31:PreW];
`else
  assign pad_rgb = ~(pwm_q & {3{ctrl_q[CtrlCurren] & ctrl_q[CtrlLeden]}});

  // Current settings only mean something to the hard driver.
  logic unused_bits;
  assign unused_bits = ^{wb_wdata[31:PreW], CURRENT_MODE, RGB0_CURRENT, RGB1_CURRENT,
                         RGB2_CURRENT};
`endif

endmodule

// File: tb/tb_ice40_rgb_wb_ctrl.sv
// Scoreboarded bench for ice40_rgb_wb_ctrl: bus reads checked by a monitor against a
// register model, PWM checked by counting low pad clocks over whole periods.
module tb_ice40_rgb_wb_ctrl;

  logic        clk_4x_s = 1'b0;
  logic        rst      = 1'b1;
  logic [2:0]  pad_rgb;
  logic [4:0]  wb_addr  = '0;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata = '0;
  logic        wb_we    = 1'b0;
  logic        wb_cyc   = 1'b0;
  logic        wb_ack;

  always #5 clk_4x_s = ~clk_4x_s;

  ice40_rgb_wb_ctrl dut (
    .clk_4x_s (clk_4x_s),
    .rst      (rst),
    .pad_rgb  (pad_rgb),
    .wb_addr  (wb_addr),
    .wb_rdata (wb_rdata),
    .wb_wdata (wb_wdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack)
  );

  typedef struct {
    bit          chk;
    logic [31:0] d;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  // Register model
  logic [2:0]  m_ctrl;
  logic [11:0] m_pre;
  logic [7:0]  m_duty[3];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'h00:   return {29'd0, m_ctrl};
      5'h01:   return {20'd0, m_pre};
      5'h02:   return {24'd0, m_duty[0]};
      5'h03:   return {24'd0, m_duty[1]};
      5'h04:   return {24'd0, m_duty[2]};
      default: return 32'd0;  // STATUS is only checked while EN=0, where it reads 0
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = '0;
    m_pre  = '0;
    for (int i = 0; i < 3; i++) m_duty[i] = '0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    case (a)
      5'h00:   m_ctrl = d[2:0];
      5'h01:   m_pre  = d[11:0];
      5'h02:   m_duty[0] = d[7:0];
      5'h03:   m_duty[1] = d[7:0];
      5'h04:   m_duty[2] = d[7:0];
      default: ;
    endcase
  endtask

  // Monitor: compare read data whenever the DUT acknowledges
  always @(negedge clk_4x_s) begin
    if (!rst && wb_ack === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 32'(wb_ack), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk) check(mon_e.name, wb_rdata, mon_e.d);
      end
    end else if (!rst && wb_cyc === 1'b1) begin
      check("rdata_zero_outside_ack", wb_rdata, 32'd0);
    end
  end

  task automatic bus(input bit we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    int   lat;
    e.chk  = !(a == 5'h05 && m_ctrl[0]);
    e.d    = model_read(a);
    e.name = $sformatf("%s_addr%0h", we ? "wr" : "rd", a);
    sbq.push_back(e);
    @(posedge clk_4x_s); #1;
    wb_addr  = a;
    wb_we    = we;
    wb_wdata = d;
    wb_cyc   = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_4x_s); #1;
      lat++;
    end while (wb_ack !== 1'b1 && lat < 8);
    check("ack_latency", 32'(lat), 32'd1);
    @(posedge clk_4x_s); #1;
    wb_cyc = 1'b0;
    wb_we  = 1'b0;
    check("ack_one_cycle", 32'(wb_ack), 32'd0);
    if (we && lat < 8) model_write(a, d);
  endtask

  task automatic measure(input int len, output int l0, output int l1, output int l2);
    l0 = 0; l1 = 0; l2 = 0;
    repeat (len) begin
      @(negedge clk_4x_s);
      if (!pad_rgb[0]) l0++;
      if (!pad_rgb[1]) l1++;
      if (!pad_rgb[2]) l2++;
    end
  endtask

  task automatic wait_fall(output bit ok);
    bit prev;
    ok = 1'b0;
    @(negedge clk_4x_s);
    prev = pad_rgb[0];
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk_4x_s);
      if (prev && !pad_rgb[0]) begin
        ok = 1'b1;
        break;
      end
      prev = pad_rgb[0];
    end
  endtask

  // Configure from a stopped state, let one full period settle, then count low clocks
  task automatic pwm_trial(input string nm, input int p, input int d0, input int d1,
                           input int d2, input logic [2:0] ctrl);
    int          per;
    int          l0, l1, l2;
    int          mult;
    logic [31:0] r;
    per = 256 * (p + 1);
    bus(1'b1, 5'h00, 32'd0);
    bus(1'b0, 5'h05, 32'd0);
    r = $urandom();
    bus(1'b1, 5'h01, {r[31:12], 12'(p)});
    r = $urandom();
    bus(1'b1, 5'h02, {r[31:8], 8'(d0)});
    r = $urandom();
    bus(1'b1, 5'h03, {r[31:8], 8'(d1)});
    r = $urandom();
    bus(1'b1, 5'h04, {r[31:8], 8'(d2)});
    r = $urandom();
    bus(1'b1, 5'h00, {r[31:3], ctrl});
    repeat (per + 8) @(posedge clk_4x_s);
    measure(per, l0, l1, l2);
    mult = (m_ctrl == 3'b111) ? (int'(m_pre) + 1) : 0;
    check({nm, "_ch0_low"}, 32'(l0), 32'(int'(m_duty[0]) * mult));
    check({nm, "_ch1_low"}, 32'(l1), 32'(int'(m_duty[1]) * mult));
    check({nm, "_ch2_low"}, 32'(l2), 32'(int'(m_duty[2]) * mult));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          lows;
    int          run;
    logic [4:0]  a;
    logic [31:0] r;
    model_reset();

    // Reset
    repeat (3) @(posedge clk_4x_s);
    @(negedge clk_4x_s);
    check("rst_pad", 32'(pad_rgb), 32'h7);
    check("rst_ack", 32'(wb_ack), 32'd0);
    check("rst_rdata", wb_rdata, 32'd0);
    @(posedge clk_4x_s); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) bus(1'b0, 5'(i), 32'd0);

    // Bus
    bus(1'b1, 5'h02, 32'h000000AB);
    bus(1'b0, 5'h02, 32'd0);
    bus(1'b1, 5'h1F, 32'hFFFFFFFF);
    bus(1'b0, 5'h1F, 32'd0);
    for (int i = 0; i < 6; i++) begin
      a = 5'($urandom_range(6, 31));
      bus(1'b1, a, $urandom());
      bus(1'b0, a, 32'd0);
    end

    // Directed PWM cases, then random ones
    pwm_trial("duty64",  0, 64, 0, 0, 3'b111);
    pwm_trial("extreme", 0, 0, 255, 0, 3'b111);
    pwm_trial("nocurr",  0, 200, 100, 50, 3'b101);
    pwm_trial("pre3",    3, 17, 128, 255, 3'b111);
    for (int t = 0; t < 4; t++) begin
      r = $urandom();
      pwm_trial($sformatf("rand%0d", t), $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255),
                r[0] ? 3'b111 : 3'($urandom_range(0, 7)));
      for (int i = 0; i < 5; i++) bus(1'b0, 5'(i), 32'd0);
    end
    bus(1'b1, 5'h00, 32'd0);
    bus(1'b0, 5'h05, 32'd0);

    // Mid-period duty change must wait for the wrap
    pwm_trial("pre_glitch", 0, 128, 0, 0, 3'b111);
    wait_fall(ok);
    check("glitch_first_fall", 32'(ok), 32'd1);
    repeat (150) @(negedge clk_4x_s);
    bus(1'b1, 5'h02, 32'd200);
    lows = 0;
    repeat (30) begin
      @(negedge clk_4x_s);
      if (!pad_rgb[0]) lows++;
    end
    check("glitch_no_early_change", 32'(lows), 32'd0);
    wait_fall(ok);
    check("glitch_second_fall", 32'(ok), 32'd1);
    run = 1;
    while (run < 300) begin
      @(negedge clk_4x_s);
      if (pad_rgb[0]) break;
      run++;
    end
    check("glitch_new_duty_len", 32'(run), 32'd200);

    // Reset in the middle of a running period
    @(posedge clk_4x_s); #1;
    rst = 1'b1;
    @(negedge clk_4x_s);
    check("midrst_pad", 32'(pad_rgb), 32'h7);
    check("midrst_ack", 32'(wb_ack), 32'd0);
    @(posedge clk_4x_s); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) bus(1'b0, 5'(i), 32'd0);
    check("queue_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
